// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operation request in, registered results and status out.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       aluCtr;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH-1:0] aluHi;
  logic             zero;
  logic             divZero;

  modport master (
    output start, aluCtr, input1, input2,
    input  busy, done, aluRes, aluHi, zero, divZero
  );

  modport slave (
    input  start, aluCtr, input1, input2,
    output busy, done, aluRes, aluHi, zero, divZero
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned multiply and
// restoring divide, one bit per cycle, with registered results and a start/busy/done handshake.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             busy_q, done_q, zero_q, div_zero_q;
  logic [WIDTH-1:0] res_q, res_hi_q;

  logic [WIDTH:0]   mul_sum, div_shl, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo, op_res;

  // hi/lo hold {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV,
  // so both loops leave the final {aluHi, aluRes} pair in {hi, lo}.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shl  = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_shl - {1'b0, opnd_q};
    div_ge   = ~div_diff[WIDTH];
    if (state_q == StMul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shl[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    op_res = '0;
    case (bus.aluCtr)
      4'b0010: op_res = bus.input1 + bus.input2;
      4'b0110: op_res = bus.input1 - bus.input2;
      4'b0000: op_res = bus.input1 & bus.input2;
      4'b0001: op_res = bus.input1 | bus.input2;
      4'b0111: op_res = {{(WIDTH-1){1'b0}}, (bus.input1 < bus.input2)};
      4'b1100: op_res = ~(bus.input1 | bus.input2);
      default: op_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= '0;
      res_hi_q   <= '0;
      zero_q     <= 1'b1;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.aluCtr == 4'b1000 || (bus.aluCtr == 4'b1001 && bus.input2 != '0)) begin
              state_q <= (bus.aluCtr == 4'b1000) ? StMul : StDiv;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              hi_q    <= '0;
              lo_q    <= bus.input1;
              opnd_q  <= bus.input2;
            end else if (bus.aluCtr == 4'b1001) begin
              res_q      <= '1;
              res_hi_q   <= bus.input1;
              zero_q     <= 1'b0;
              div_zero_q <= 1'b1;
              done_q     <= 1'b1;
            end else begin
              res_q      <= op_res;
              res_hi_q   <= '0;
              zero_q     <= (op_res == '0);
              div_zero_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        default: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            res_q      <= step_lo;
            res_hi_q   <= step_hi;
            zero_q     <= (step_lo == '0);
            div_zero_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aluRes  = res_q;
  assign bus.aluHi   = res_hi_q;
  assign bus.zero    = zero_q;
  assign bus.divZero = div_zero_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the datapath execute stage. It keeps the existing 4-bit ALU control encoding for single-cycle ops and adds iterative unsigned multiply and divide behind a start/busy/done handshake. All results and flags are registered, and `zero` is valid for every operation, not only subtract. The control unit stalls the pipeline on `busy`.

## Interface
- `WIDTH`, 32, operand/result width (≥2)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `aluCtr`  in  4  operation select, sampled with `start`
- `input1`  in  WIDTH  operand A, sampled with `start`
- `input2`  in  WIDTH  operand B, sampled with `start`
- `busy`  out  1  multi-cycle op in progress
- `done`  out  1  one-cycle pulse: results updated
- `aluRes`  out  WIDTH  result / product low / quotient
- `aluHi`  out  WIDTH  product high / remainder; 0 for single-cycle ops
- `zero`  out  1  `aluRes`==0
- `divZero`  out  1  last op was divide with `input2`=0

## Operation
- Encodings:
  - 0010 add
  - 0110 sub
  - 0000 and
  - 0001 or
  - 0111 set-less-than, unsigned; result 1 or 0
  - 1100 nor (`~(A|B)`)
  - 1000 unsigned multiply
  - 1001 unsigned divide
  - any other code: `aluRes`=0, completes as a single-cycle op
- Add and sub wrap modulo 2^WIDTH; no overflow flag.
- States:
  - IDLE: accepts `start`.
  - MUL: shift-add loop, one bit per cycle, WIDTH iterations. Operands are latched at start; the 2·WIDTH product is written as {`aluHi`,`aluRes`}.
  - DIV: restoring division, one bit per cycle, WIDTH iterations.
- Transitions:
  - IDLE + start + single-cycle code → IDLE. Results are written on the sampling edge.
  - IDLE + start + 1000 → MUL.
  - IDLE + start + 1001, `input2`≠0 → DIV.
  - IDLE + start + 1001, `input2`=0 → IDLE, completing in one cycle with `aluRes`=all ones, `aluHi`=`input1`, `divZero`=1.
  - MUL/DIV → IDLE on the edge where the iteration counter reaches WIDTH.
- `divZero` is rewritten on every completion: 0 for all ops except divide-by-zero.
- `zero` is recomputed from the final `aluRes` on every completion.
- Outputs hold their values between completions. Operand and control changes while busy have no effect.
- `start` while `busy`=1 is ignored and is not queued.

## Timing
- Reset values:
  - `busy`=0, `done`=0
  - `aluRes`=0, `aluHi`=0
  - `zero`=1
  - `divZero`=0
  - state IDLE, counter 0
- Single-cycle ops and divide-by-zero: sampled at edge E0. Results are valid and `done`=1 in the cycle after E0, with latency 1.
- Mul/div: `busy`=1 from after E0 until after edge E0+WIDTH. At E0+WIDTH the results are written, `busy`→0 and `done`=1 for that one cycle. Latency is WIDTH+1 cycles from the start cycle to the done cycle.
- Back-to-back: `start` may be asserted in the cycle where `done`=1. The new op is accepted because the state is IDLE.
- `done` is high for exactly one cycle per accepted request. `done` and `busy` are never both 1.
- Reset mid-operation: the operation is abandoned and no `done` is issued. All outputs return to reset values on that edge.
- `reset` has priority over `start` in the same cycle.

## Test plan
- Reset, then start 0110 with `input1`=5, `input2`=5 → next cycle: `done`=1, `aluRes`=0, `zero`=1, `aluHi`=0.
- Start 1000 with `input1`=`input2`=0xFFFFFFFF → `busy` for 32 cycles, then `done` at cycle 33 with `aluHi`=0xFFFFFFFE, `aluRes`=0x00000001, `zero`=0.
- Start 1001 with `input1`=100, `input2`=7 → `done` after 32 busy cycles with `aluRes`=14, `aluHi`=2, `divZero`=0.
- Start 1001 with `input1`=0x1234, `input2`=0 → 1-cycle completion with `aluRes`=0xFFFFFFFF, `aluHi`=0x1234, `divZero`=1, `busy` never set.
- During a multiply, pulse `start` with 0010 (3+4) at busy cycle 10 → ignored; the product completes normally. 0010 issued in the `done` cycle → `aluRes`=7 one cycle later.
- Assert `reset` at busy cycle 5 of a divide → no `done`; the cycle after reset shows `busy`=0, `aluRes`=0, `zero`=1. A following 0111 op with 3,9 → `aluRes`=1.
